// File: rtl/mac_pkg.sv
// Shared types and widths for the dot-product sequencer and its MAC.
package mac_pkg;

  localparam int MAC_IN_W  = 16;
  localparam int MAC_ACC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

endpackage

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: feeds one (a,b) pair at a time to an external MAC and
// chains the partial sum through acc. Optional sticky wrap flag: MAC_DOT_OVF_EN.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAC_IN_W-1:0]  in_a,
  input  logic [MAC_IN_W-1:0]  in_b,
  output logic [MAC_IN_W-1:0]  mac_a,
  output logic [MAC_IN_W-1:0]  mac_b,
  output logic [MAC_ACC_W-1:0] mac_acc,
  input  logic [MAC_ACC_W-1:0] mac_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [MAC_ACC_W-1:0] res_data,
`ifdef MAC_DOT_OVF_EN
  output logic                 ovf,
`endif
  output mac_state_e           state_dbg
);

  localparam int LAT_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

  mac_state_e             state_q, state_d;
  logic [LEN_W-1:0]       rem_q, rem_d;
  logic [LAT_W-1:0]       lat_q, lat_d;
  logic [MAC_ACC_W-1:0]   psum_q, psum_d;
  logic [MAC_IN_W-1:0]    mac_a_q, mac_a_d;
  logic [MAC_IN_W-1:0]    mac_b_q, mac_b_d;
  logic [MAC_ACC_W-1:0]   mac_acc_q, mac_acc_d;
  logic [MAC_ACC_W-1:0]   res_data_q, res_data_d;

  logic start_acc;
  logic in_fire;
  logic wait_sample;
  logic last_elem;

  // Both streams: a transfer happens on the rising edge where valid && ready;
  // in_ready depends on state only, and valid may be held or dropped freely.
  assign start_acc   = (state_q == ST_IDLE) && start;
  assign in_fire     = (state_q == ST_FETCH) && in_valid;
  assign wait_sample = (state_q == ST_WAIT) && (lat_q == LAT_W'(1));
  assign last_elem   = (rem_q == LEN_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_FETCH;
      ST_FETCH: if (in_valid) state_d = ST_WAIT;
      ST_WAIT:  if (lat_q == LAT_W'(1)) state_d = last_elem ? ST_DONE : ST_FETCH;
      ST_DONE:  if (res_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    in_ready  = (state_q == ST_FETCH);
    res_valid = (state_q == ST_DONE);
    state_dbg = state_q;
  end

  always_comb begin
    rem_d      = rem_q;
    lat_d      = lat_q;
    psum_d     = psum_q;
    mac_a_d    = mac_a_q;
    mac_b_d    = mac_b_q;
    mac_acc_d  = mac_acc_q;
    res_data_d = res_data_q;
    if (start_acc) begin
      rem_d  = len;
      psum_d = '0;
      if (len == '0) res_data_d = '0;
    end
    if (in_fire) begin
      mac_a_d   = in_a;
      mac_b_d   = in_b;
      mac_acc_d = psum_q;
      lat_d     = LAT_W'(MAC_LAT);
    end
    // The MAC result is only trusted on the last cycle of the latency window.
    if (state_q == ST_WAIT) begin
      if (lat_q == LAT_W'(1)) begin
        lat_d  = '0;
        psum_d = mac_out;
        rem_d  = rem_q - LEN_W'(1);
        if (last_elem) res_data_d = mac_out;
      end else begin
        lat_d = lat_q - LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q      <= '0;
      lat_q      <= '0;
      psum_q     <= '0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_acc_q  <= '0;
      res_data_q <= '0;
    end else begin
      rem_q      <= rem_d;
      lat_q      <= lat_d;
      psum_q     <= psum_d;
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      mac_acc_q  <= mac_acc_d;
      res_data_q <= res_data_d;
    end
  end

  assign mac_a    = mac_a_q;
  assign mac_b    = mac_b_q;
  assign mac_acc  = mac_acc_q;
  assign res_data = res_data_q;

`ifdef MAC_DOT_OVF_EN
  logic ovf_q, ovf_d;

  // Unsigned wrap shows up as a result smaller than the accumulator fed in.
  always_comb begin
    ovf_d = ovf_q;
    if (start_acc) ovf_d = 1'b0;
    else if (wait_sample && (mac_out < mac_acc_q)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mac_dot_seq.sv
// Bench for mac_dot_seq with a behavioural MAC and a dot-product reference model.
module tb_mac_dot_seq;
  import mac_pkg::*;

  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 2;
  localparam int TIMEOUT = 500;

  logic        clk;
  logic        rst;
  logic        start;
  logic [LEN_W-1:0] len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [31:0] mac_acc;
  logic [31:0] mac_out;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
`ifdef MAC_DOT_OVF_EN
  logic        ovf;
`endif
  mac_state_e  state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ready_cnt = 0;

  logic [31:0] exp_q[$];
  logic [15:0] va[$];
  logic [15:0] vb[$];

  mac_dot_seq #(.LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
`ifdef MAC_DOT_OVF_EN
    .ovf(ovf),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_ready) ready_cnt <= ready_cnt + 1;
  end

  // Behavioural MAC: a*b+acc, available MAC_LAT cycles after its inputs change.
  logic [31:0] mac_val;
  assign mac_val = {16'h0, mac_a} * {16'h0, mac_b} + mac_acc;

  generate
    if (MAC_LAT == 1) begin : g_comb
      assign mac_out = mac_val;
    end else begin : g_pipe
      logic [31:0] pipe [MAC_LAT-1];
      always @(posedge clk) begin
        pipe[0] <= mac_val;
        for (int i = 1; i < MAC_LAT - 1; i++) pipe[i] <= pipe[i-1];
      end
      assign mac_out = pipe[MAC_LAT-2];
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit running sum, folded back whenever it passes 2^32.
  function automatic void ref_model(output logic [31:0] sum, output bit wrapped);
    logic [63:0] s;
    s = 64'd0;
    wrapped = 1'b0;
    for (int i = 0; i < va.size(); i++) begin
      s = s + 64'(va[i]) * 64'(vb[i]);
      if (s >= 64'h1_0000_0000) begin
        wrapped = 1'b1;
        s = s - 64'h1_0000_0000;
      end
    end
    sum = s[31:0];
  endfunction

  task automatic feed_one(input logic [15:0] a, input logic [15:0] b, output bit ok);
    int t;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    t = 0;
    while (!in_ready && t < TIMEOUT) begin
      @(posedge clk); #1;
      t++;
    end
    ok = (t < TIMEOUT);
    if (!ok) check_eq("in_ready_timeout", 32'd0, 32'd1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_a = 16'($urandom);
    in_b = 16'($urandom);
  endtask

  task automatic run_job(input int n, input int gap_max, input bit chk_lat, input int hold);
    logic [31:0] exp_sum;
    logic [31:0] psum;
    bit exp_ovf;
    bit ok;
    int s_cyc, t, g, r0;
    ref_model(exp_sum, exp_ovf);
    exp_q.push_back(exp_sum);
    start = 1'b1;
    len = LEN_W'(n);
    r0 = ready_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    s_cyc = cyc;
    psum = 32'd0;
    for (int i = 0; i < n; i++) begin
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      repeat (g) begin
        start = 1'($urandom_range(0, 1));
        len = LEN_W'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
      end
      feed_one(va[i], vb[i], ok);
      if (!ok) return;
      for (int k = 0; k < MAC_LAT; k++) begin
        check_eq("wait_mac_a", 32'(mac_a), 32'(va[i]));
        check_eq("wait_mac_b", 32'(mac_b), 32'(vb[i]));
        check_eq("wait_mac_acc", mac_acc, psum);
        check_eq("wait_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
      end
      psum = psum + {16'h0, va[i]} * {16'h0, vb[i]};
    end
    t = 0;
    while (!res_valid && t < TIMEOUT) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("res_valid_seen", 32'(res_valid), 32'd1);
    if (chk_lat) check_eq("res_latency", 32'(cyc - s_cyc), 32'(n * (1 + MAC_LAT)));
    if (n == 0) check_eq("len0_no_ready", 32'(ready_cnt - r0), 32'd0);
    repeat (hold) begin
      check_eq("hold_valid", 32'(res_valid), 32'd1);
      check_eq("hold_data", res_data, exp_sum);
      start = 1'($urandom_range(0, 1));
      len = LEN_W'($urandom_range(1, 9));
      @(posedge clk); #1;
      start = 1'b0;
    end
`ifdef MAC_DOT_OVF_EN
    check_eq("ovf", 32'(ovf), 32'(exp_ovf));
`endif
    check_eq("res_data", res_data, exp_q.pop_front());
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_eq("post_res_valid", 32'(res_valid), 32'd0);
    check_eq("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_zero_outputs(input string pfx);
    check_eq({pfx, "_busy"}, 32'(busy), 32'd0);
    check_eq({pfx, "_in_ready"}, 32'(in_ready), 32'd0);
    check_eq({pfx, "_res_valid"}, 32'(res_valid), 32'd0);
    check_eq({pfx, "_res_data"}, res_data, 32'd0);
    check_eq({pfx, "_mac_a"}, 32'(mac_a), 32'd0);
    check_eq({pfx, "_mac_b"}, 32'(mac_b), 32'd0);
    check_eq({pfx, "_mac_acc"}, mac_acc, 32'd0);
`ifdef MAC_DOT_OVF_EN
    check_eq({pfx, "_ovf"}, 32'(ovf), 32'd0);
`endif
  endtask

  initial begin
    bit ok;
    int n;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    va = '{16'd2, 16'd4, 16'd6};
    vb = '{16'd3, 16'd5, 16'd7};
    run_job(3, 0, 1'b1, 0);

    va.delete(); vb.delete();
    run_job(0, 0, 1'b1, 0);

    va = '{16'hFFFF, 16'hFFFF};
    vb = '{16'hFFFF, 16'hFFFF};
    run_job(2, 0, 1'b1, 0);

    va = '{16'd1, 16'd1};
    vb = '{16'd1, 16'd1};
    run_job(2, 0, 1'b1, 0);

    va = '{16'($urandom), 16'($urandom), 16'($urandom)};
    vb = '{16'($urandom), 16'($urandom), 16'($urandom)};
    run_job(3, 0, 1'b1, 10);

    va = '{16'd1, 16'd1, 16'd1, 16'd1};
    vb = '{16'd1, 16'd1, 16'd1, 16'd1};
    run_job(4, 3, 1'b0, 2);

    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(1, 8);
      va.delete(); vb.delete();
      for (int i = 0; i < n; i++) begin
        va.push_back(16'($urandom));
        vb.push_back(16'($urandom));
      end
      run_job(n, 2, 1'b0, $urandom_range(0, 3));
    end

    // Reset while element 2 of a 3-element job is in flight.
    start = 1'b1;
    len = LEN_W'(3);
    @(posedge clk); #1;
    start = 1'b0;
    feed_one(16'd5, 16'd6, ok);
    repeat (MAC_LAT) @(posedge clk);
    #1;
    feed_one(16'd7, 16'd8, ok);
    check_eq("pre_rst_in_wait", 32'(state_dbg), 32'(ST_WAIT));
    rst = 1'b1;
    #1;
    check_zero_outputs("midjob_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    va = '{16'd3};
    vb = '{16'd3};
    run_job(1, 0, 1'b1, 0);

    check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
Sequencer that computes an unsigned dot product of length len with the existing 16x16 MAC pipeline. It accepts (a,b) element pairs over a valid/ready stream and issues them one at a time to the MAC, feeding the previous partial sum back as acc. It returns the 32-bit result over a valid/ready handshake. The MAC is instantiated by the parent alongside this block; this block only drives and samples its ports.

Parameters:
LEN_W, 8, width of vector-length field; max length 2^LEN_W-1
MAC_LAT, 2, cycles from MAC inputs driven/stable to mac_out valid (min 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a job when IDLE
len  in  LEN_W  element count, sampled on accepted start
busy  out  1  high in every state except IDLE
in_valid  in  1  element pair valid
in_ready  out  1  block can take a pair this cycle
in_a  in  16  multiplicand element
in_b  in  16  multiplier element
mac_a  out  16  to MAC a (registered)
mac_b  out  16  to MAC b (registered)
mac_acc  out  32  to MAC acc (registered)
mac_out  in  32  from MAC out
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  32  dot-product result

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, in_ready=0, res_valid=0, res_data=0, mac_a=0, mac_b=0, mac_acc=0; remaining count=0, lat counter=0, partial sum=0.
- States: IDLE, FETCH, WAIT, DONE.
- IDLE: start=1 latches len into remaining and clears partial sum. If len==0, go to DONE with res_data=0. Otherwise go to FETCH. start is ignored in every other state.
- FETCH: in_ready=1 (combinational from state only, not from in_valid). On in_valid&&in_ready, register mac_a=in_a, mac_b=in_b, mac_acc=partial sum, set lat counter=MAC_LAT, go to WAIT.
- WAIT: in_ready=0; mac_a/mac_b/mac_acc are held constant. The counter decrements each cycle. When it reaches 1, sample mac_out into the partial sum and decrement remaining. If remaining becomes 0, go to DONE with res_data=mac_out. Otherwise go to FETCH.
- Each element therefore costs at least 1+MAC_LAT cycles. No issue overlap, because each acc depends on the previous result.
- DONE: res_valid=1; res_data is stable until the handshake. On res_ready, clear res_valid and go to IDLE. start is not accepted in the same cycle as the handshake.
- Arithmetic: unsigned; the 32-bit sum wraps modulo 2^32 with no saturation.
- Bubbles: in_valid low in FETCH simply stalls there, with no timeout.
- Reset mid-job: job is discarded, no result is emitted, and outputs return to reset values.

Optional Feature:
MAC_DOT_OVF_EN: when defined, adds output port ovf (1 bit).
- ovf is a sticky flag, cleared on accepted start.
- It sets when a sampled mac_out < mac_acc (unsigned wrap) on any element.
- It is valid alongside res_valid and its reset value is 0.
When the macro is undefined, the port and its logic are absent and wrap is silent.

Decomposition:
- Shared package mac_pkg: state enum type; constants MAC_IN_W=16, MAC_ACC_W=32.
- No sub-module: the state machine plus two counters is a single module. The MAC itself stays a separate instance in the parent.

Test Plan:
- len=3, pairs (2,3),(4,5),(6,7) with in_valid always high -> res_data=0x00000044 (68). res_valid rises 3*(1+MAC_LAT)+1 cycles after start.
- len=0 start -> DONE next cycle with res_data=0; no in_ready pulse ever.
- len=2, pairs (0xFFFF,0xFFFF) twice -> res_data=0xFFFC0002. With MAC_DOT_OVF_EN, ovf=1; with (1,1) twice, ovf=0.
- Backpressure: hold res_ready=0 for 10 cycles -> res_valid and res_data stable; start pulses during busy ignored; next job result is independent of the previous one.
- Stalls: random in_valid gaps on len=4, (1,1)x4 -> res_data=4; mac_a/mac_b/mac_acc never change during WAIT.
- Reset asserted during WAIT of element 2 -> all outputs 0 in the same cycle. A following job len=1, (3,3) returns 9.
